// File: rtl/ram_arb_pkg.sv
// Shared types and default geometry for the sample RAM and its port arbiter.
package ram_arb_pkg;

  localparam int RAM_ADDR_W = 14;
  localparam int RAM_DATA_W = 64;
  localparam int RAM_BE_W   = RAM_DATA_W / 8;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_WR   = 2'd1,
    OWN_RD   = 2'd2
  } owner_e;

endpackage

// File: rtl/ram_arb_rd_pipe.sv
// Read-return pipe: tracks in-flight reads and captures RAM data RD_LATENCY
// cycles after each read strobe.
module ram_arb_rd_pipe #(
  parameter int DATA_W     = 64,
  parameter int RD_LATENCY = 2
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_rden,
  input  logic [DATA_W-1:0] i_ram_q,
  output logic              o_rd_valid,
  output logic [DATA_W-1:0] o_rd_data
);

  // vld_q[k] is high k+1 cycles after the strobe; the top bit is the output valid.
  logic [RD_LATENCY:0] vld_q, vld_d;
  logic [DATA_W-1:0]   data_q, data_d;

  always_comb begin
    vld_d  = {vld_q[RD_LATENCY-1:0], i_rden};
    data_d = data_q;
    if (vld_q[RD_LATENCY-1]) data_d = i_ram_q;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      vld_q  <= '0;
      data_q <= '0;
    end else begin
      vld_q  <= vld_d;
      data_q <= data_d;
    end
  end

  assign o_rd_valid = vld_q[RD_LATENCY];
  assign o_rd_data  = data_q;

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one RAM port between the sample writer and the readout reader.
// Define RAM_ARB_WR_PRIORITY_EN to give the writer every tie instead of round-robin.
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_W     = RAM_ADDR_W,
  parameter int DATA_W     = RAM_DATA_W,
  parameter int BE_W       = RAM_BE_W,
  parameter int RD_LATENCY = 2
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_wr_req,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic [BE_W-1:0]   i_wr_byteen,
  output logic              o_wr_ack,
  input  logic              i_rd_req,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic              o_rd_ack,
  output logic [DATA_W-1:0] o_rd_data,
  output logic              o_rd_valid,
  output logic [ADDR_W-1:0] o_ram_addr,
  output logic [DATA_W-1:0] o_ram_data,
  output logic [BE_W-1:0]   o_ram_byteen,
  output logic              o_ram_wren,
  output logic              o_ram_rden,
  input  logic [DATA_W-1:0] i_ram_q,
  output logic [31:0]       o_wr_count
);

  // Handshake: a requester holds req (and its operands) until ack; ack is a
  // one-cycle pulse in the cycle the access is on the RAM port.
  owner_e            owner_q, owner_d;
  logic              last_wr_q, last_wr_d;
  logic              wr_elig, rd_elig;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_data_q, ram_data_d;
  logic [BE_W-1:0]   ram_byteen_q, ram_byteen_d;
  logic              ram_wren_q, ram_wren_d;
  logic              ram_rden_q, ram_rden_d;
  logic              wr_ack_q, wr_ack_d;
  logic              rd_ack_q, rd_ack_d;
  logic [31:0]       wr_count_q, wr_count_d;

  always_comb begin
    // The current owner's ack masks its still-held request for one cycle.
    wr_elig = i_wr_req && (owner_q != OWN_WR);
    rd_elig = i_rd_req && (owner_q != OWN_RD);

    owner_d = OWN_NONE;
    if (wr_elig && rd_elig) begin
`ifdef RAM_ARB_WR_PRIORITY_EN
      owner_d = OWN_WR;
`else
      owner_d = last_wr_q ? OWN_RD : OWN_WR;
`endif
    end else if (wr_elig) begin
      owner_d = OWN_WR;
    end else if (rd_elig) begin
      owner_d = OWN_RD;
    end

    last_wr_d    = last_wr_q;
    ram_addr_d   = '0;
    ram_data_d   = '0;
    ram_byteen_d = '0;
    ram_wren_d   = 1'b0;
    ram_rden_d   = 1'b0;
    wr_ack_d     = 1'b0;
    rd_ack_d     = 1'b0;
    wr_count_d   = wr_count_q;

    case (owner_d)
      OWN_WR: begin
        last_wr_d    = 1'b1;
        ram_addr_d   = i_wr_addr;
        ram_data_d   = i_wr_data;
        ram_byteen_d = i_wr_byteen;
        ram_wren_d   = 1'b1;
        wr_ack_d     = 1'b1;
        wr_count_d   = wr_count_q + 32'd1;
      end
      OWN_RD: begin
        last_wr_d  = 1'b0;
        ram_addr_d = i_rd_addr;
        ram_rden_d = 1'b1;
        rd_ack_d   = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      owner_q      <= OWN_NONE;
      last_wr_q    <= 1'b1;
      ram_addr_q   <= '0;
      ram_data_q   <= '0;
      ram_byteen_q <= '0;
      ram_wren_q   <= 1'b0;
      ram_rden_q   <= 1'b0;
      wr_ack_q     <= 1'b0;
      rd_ack_q     <= 1'b0;
      wr_count_q   <= '0;
    end else begin
      owner_q      <= owner_d;
      last_wr_q    <= last_wr_d;
      ram_addr_q   <= ram_addr_d;
      ram_data_q   <= ram_data_d;
      ram_byteen_q <= ram_byteen_d;
      ram_wren_q   <= ram_wren_d;
      ram_rden_q   <= ram_rden_d;
      wr_ack_q     <= wr_ack_d;
      rd_ack_q     <= rd_ack_d;
      wr_count_q   <= wr_count_d;
    end
  end

  assign o_ram_addr   = ram_addr_q;
  assign o_ram_data   = ram_data_q;
  assign o_ram_byteen = ram_byteen_q;
  assign o_ram_wren   = ram_wren_q;
  assign o_ram_rden   = ram_rden_q;
  assign o_wr_ack     = wr_ack_q;
  assign o_rd_ack     = rd_ack_q;
  assign o_wr_count   = wr_count_q;

  ram_arb_rd_pipe #(
    .DATA_W     (DATA_W),
    .RD_LATENCY (RD_LATENCY)
  ) u_rd_pipe (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_rden     (ram_rden_q),
    .i_ram_q    (i_ram_q),
    .o_rd_valid (o_rd_valid),
    .o_rd_data  (o_rd_data)
  );

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Shares the single write/read port of the 16K x 64 sample RAM between two requesters: the sample writer (write-only) and the host readout path (read-only).
- Arbitrates per cycle, drives registered RAM control signals, and returns read data after a fixed latency.
- Sits between the sample producer and the RAM macro. The readout engine becomes a second requester instead of owning a separate port.

Parameters:
- ADDR_W, 14, RAM word address width.
- DATA_W, 64, RAM data width.
- BE_W, 8, byte-enable width (DATA_W/8).
- RD_LATENCY, 2, cycles from o_ram_rden high to i_ram_q valid. Legal range 1..4.

Ports:
- i_clk  in  1  system clock, all logic on the rising edge.
- i_rst_n  in  1  reset, asynchronous assert, active-low.
- i_wr_req  in  1  writer request. Held with addr/data/byteen stable until o_wr_ack.
- i_wr_addr  in  ADDR_W  write address.
- i_wr_data  in  DATA_W  write data.
- i_wr_byteen  in  BE_W  write byte enables.
- o_wr_ack  out  1  one-cycle pulse. High in the same cycle the write is on the RAM port.
- i_rd_req  in  1  reader request. Held with addr stable until o_rd_ack.
- i_rd_addr  in  ADDR_W  read address.
- o_rd_ack  out  1  one-cycle pulse. High in the cycle o_ram_rden is high.
- o_rd_data  out  DATA_W  returned read data.
- o_rd_valid  out  1  one-cycle pulse qualifying o_rd_data.
- o_ram_addr  out  ADDR_W  RAM address.
- o_ram_data  out  DATA_W  RAM write data.
- o_ram_byteen  out  BE_W  RAM byte enables.
- o_ram_wren  out  1  RAM write strobe.
- o_ram_rden  out  1  RAM read strobe.
- i_ram_q  in  DATA_W  RAM read data.
- o_wr_count  out  32  writes issued since reset. Wraps 32'hFFFFFFFF -> 0.

Behaviour:
- Reset: every output is 0. Owner pointer is OWN_NONE. Last-grant pointer is WR, so the reader wins the first tie. The read pipe is flushed.
- Owner state per cycle, one of three:
  - OWN_NONE: RAM outputs driven to 0.
  - OWN_WR: write issued.
  - OWN_RD: read issued.
- Eligibility, evaluated at each rising edge:
  - wr_elig = i_wr_req && !o_wr_ack.
  - rd_elig = i_rd_req && !o_rd_ack.
  - The ack mask stops a held request from being issued twice. Each requester is limited to one access per 2 cycles. Alternating requesters together can use every cycle.
- Next owner:
  - Neither eligible -> OWN_NONE.
  - Exactly one eligible -> that one.
  - Both eligible -> the one not granted last (round-robin). The last-grant pointer updates only on an actual grant.
- Issue latency: a request sampled at edge N is on the RAM port and acked in the cycle after edge N. All RAM outputs and acks are registered.
- OWN_WR cycle:
  - o_ram_wren=1, o_ram_rden=0, o_wr_ack=1.
  - o_ram_addr/data/byteen = captured i_wr_* values.
  - o_wr_count increments.
- OWN_RD cycle:
  - o_ram_rden=1, o_ram_wren=0, o_rd_ack=1.
  - o_ram_addr = i_rd_addr, o_ram_data=0, o_ram_byteen=0.
- OWN_NONE cycle: addr, data, byteen, wren and rden are all 0.
- wren and rden are never high together.
- Read return:
  - rden high in cycle T -> i_ram_q sampled at the end of cycle T+RD_LATENCY.
  - o_rd_valid=1 and o_rd_data valid in cycle T+RD_LATENCY+1.
  - o_rd_data holds its value until the next valid.
  - Back-to-back reads pipeline independently. Up to RD_LATENCY+1 reads can be in flight.
- Requests dropped before their ack are simply not issued. There is no error flag.
- Addresses pass through unchanged. Wrap-around and address sequencing are the requester's job.
- Reset mid-operation: in-flight reads are discarded and no o_rd_valid is produced after reset. A pending ack is cancelled.

Optional Feature:
- RAM_ARB_WR_PRIORITY_EN
  - Defined: the writer wins every tie (fixed priority). The sample stream can never be delayed by readout. The reader is still granted whenever the writer is ineligible, including the writer's ack-mask cycle.
  - Undefined: round-robin as described above.

Decomposition:
- Package ram_arb_pkg:
  - owner enum: OWN_NONE, OWN_WR, OWN_RD.
  - Default ADDR_W/DATA_W/BE_W constants, shared with the sample writer.
- Sub-module ram_arb_rd_pipe: a RD_LATENCY+1 deep valid shift register plus the data capture register. It has its own async active-low reset.

Test Plan:
- Reset with i_rd_req and i_wr_req both high -> all outputs stay 0 until i_rst_n rises. First grant is a read, since it wins the first tie.
- Write only: addr=14'h0005, data=64'h0004_0003_0002_0001, byteen=8'hFF held -> exactly one wren cycle with those values. o_wr_ack coincides. o_wr_count=1. Held req re-issues every 2nd cycle.
- Read only, RD_LATENCY=2: rden in cycle T at addr 14'h0005, model returns 64'hDEAD_BEEF_0000_0005 -> o_rd_valid in T+3 with that data, exactly one pulse.
- Both requesting continuously -> grants alternate RD, WR, RD, WR, 100% port utilisation. wren and rden never high together.
- Reset asserted one cycle after rden -> no o_rd_valid ever appears for that read. Outputs are 0 while in reset.
- With RAM_ARB_WR_PRIORITY_EN defined, both held -> WR, RD, WR, RD (writer wins every tie, reader fills the writer's mask cycle). Writer latency is never more than 1 cycle.
